fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS datapath, sitting directly downstream of `program_counter_unit`. It presents the current PC to the instruction cache and captures the returned instruction with PC+4 into the IF/ID latch. It drives the PC unit's `ihit` advance strobe. It absorbs decode stalls with a one-entry skid buffer, kills wrong-path fetches on flush, and stops fetching after a halt.

---
 rtl/fetch_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// A one-entry skid buffer absorbs decode stalls; fetch stops on a halt opcode.
module fetch_stage #(
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        flush,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        pc_advance,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_npc_q, ifid_npc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_npc_q, skid_npc_d;
  logic [XLEN-1:0] npc_c;

  assign npc_c      = pc + XLEN'(4);
  assign imemaddr   = pc;
  assign imemREN    = (state_q == RUN);
  assign halted     = (state_q == HALT);
  assign ifid_instr = ifid_instr_q;
  assign ifid_npc   = ifid_npc_q;
  assign ifid_valid = ifid_valid_q;

  // Next-state, IF/ID/skid update and PC-advance strobe; flush > stall > normal.
  always_comb begin
    state_d      = state_q;
    ifid_instr_d = ifid_instr_q;
    ifid_npc_d   = ifid_npc_q;
    ifid_valid_d = ifid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_npc_d   = skid_npc_q;
    pc_advance   = 1'b0;

    case (state_q)
      RUN: begin
        if (flush) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          pc_advance   = 1'b1;
        end else if (stall) begin
          if (ihit) begin
            skid_instr_d = imemload;
            skid_npc_d   = npc_c;
            pc_advance   = 1'b1;
            state_d      = HOLD;
          end
        end else if (ihit) begin
          ifid_instr_d = imemload;
          ifid_npc_d   = npc_c;
          ifid_valid_d = 1'b1;
          pc_advance   = 1'b1;
          if (imemload[31:26] == HALT_OP) state_d = HALT;
        end else begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          skid_instr_d = '0;
          skid_npc_d   = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          pc_advance   = 1'b1;
          state_d      = RUN;
        end else if (!stall) begin
          // PC already moved past the buffered word, so drain without refetch.
          ifid_instr_d = skid_instr_q;
          ifid_npc_d   = skid_npc_q;
          ifid_valid_d = 1'b1;
          state_d      = (skid_instr_q[31:26] == HALT_OP) ? HALT : RUN;
        end
      end
      HALT: begin
        if (flush) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          pc_advance   = 1'b1;
          state_d      = RUN;
        end else if (!stall) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= RUN;
      ifid_instr_q <= '0;
      ifid_npc_q   <= '0;
      ifid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_npc_q   <= '0;
    end else begin
      state_q      <= state_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_npc_q   <= ifid_npc_d;
      ifid_valid_q <= ifid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_npc_q   <= skid_npc_d;
    end
  end

endmodule
